// File: rtl/write_address_sequencer.sv
// Write-side address sequencer: fills one register-file frame through a one-hot
// pointer ring, then holds it until the read side reports it consumed.
module write_address_sequencer #(
  parameter int NUM_REGS       = 15,
  parameter int INIT_WRITE_REG = 0,
  parameter int DATA_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              read_done,
  output logic              write_en,
  output logic [3:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              frame_full,
  output logic [3:0]        write_count
);

  typedef enum logic {FILL, FULL} state_t;

  localparam logic [NUM_REGS-1:0] ONE      = NUM_REGS'(1);
  localparam logic [NUM_REGS-1:0] INIT_PTR = ONE << INIT_WRITE_REG;

  state_t              state, state_nxt;
  logic [NUM_REGS-1:0] ptr, ptr_rot;
  logic [3:0]          ptr_idx;
  logic                accept, last_beat, ptr_ok, release_frame;

  // Held low during reset so upstream never sees a handshake it cannot complete.
  assign in_ready      = rst_n && (state == FILL);
  assign accept        = in_valid && in_ready;
  assign last_beat     = (write_count == 4'(NUM_REGS - 1));
  assign release_frame = (state == FULL) && read_done;
  assign ptr_rot       = {ptr[NUM_REGS-2:0], ptr[NUM_REGS-1]};
  assign ptr_ok        = (ptr != '0) && ((ptr & (ptr - ONE)) == '0);

  always_comb begin
    ptr_idx = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ptr[i]) ptr_idx = ptr_idx | 4'(i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && last_beat) state_nxt = FULL;
      FULL:    if (read_done)           state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= INIT_PTR;
      write_reg   <= 4'(INIT_WRITE_REG);
      write_en    <= 1'b0;
      write_data  <= '0;
      write_count <= '0;
      frame_full  <= 1'b0;
    end else begin
      write_en <= accept;
      if (accept) begin
        write_reg   <= ptr_idx;
        write_data  <= in_data;
        write_count <= write_count + 4'd1;
      end
      // A corrupted ring self-heals to the frame start rather than emitting a bad address.
      if (!ptr_ok)            ptr <= INIT_PTR;
      else if (accept)        ptr <= ptr_rot;
      else if (release_frame) ptr <= INIT_PTR;
      if (accept && last_beat) frame_full <= 1'b1;
      if (release_frame) begin
        frame_full  <= 1'b0;
        write_count <= '0;
      end
    end
  end

endmodule

// File: doc/write_address_sequencer.md
WRITE_ADDRESS_SEQUENCER -- requirements
Module: write_address_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- NUM_REGS, 15, number of register-file entries in one frame; legal range 2..15.
- INIT_WRITE_REG, 0, first write address of each frame; legal range 0..NUM_REGS-1.
- DATA_W, 8, width of the pixel/weight data word.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on the rising edge.
- rst_n, in, 1, synchronous, active-low reset.
- in_valid, in, 1, the upstream word on in_data is valid.
- in_data, in, DATA_W, upstream data word.
- in_ready, out, 1, the block can accept a word this cycle.
- read_done, in, 1, one-cycle pulse from the read side: the current frame has been consumed.
- write_en, out, 1, register-file write strobe.
- write_reg, out, 4, register-file write address.
- write_data, out, DATA_W, register-file write data.
- frame_full, out, 1, a complete frame is held; the read side may start.
- write_count, out, 4, number of words accepted in the current frame (0..NUM_REGS).
REQ-003 The block SHALL be clocked only by clk, with a synchronous, active-low reset rst_n; no other clocks or asynchronous resets.

Function
REQ-004 The block SHALL implement a two-state FSM: FILL and FULL.
REQ-005 In FILL, in_ready SHALL be 1. In FULL, in_ready SHALL be 0. in_ready SHALL be decoded from state only, not from in_valid.
REQ-006 A beat SHALL be accepted exactly when in_valid and in_ready are both 1 at a rising edge.
REQ-007 On an accepted beat, the block SHALL drive the following for exactly the next cycle (1-cycle registered latency):
- write_en=1
- write_data=captured in_data
- write_reg=current write pointer
REQ-008 write_en SHALL be 0 in every cycle not described by REQ-007.
REQ-009 While write_en=0, write_reg and write_data SHALL hold their last values.
REQ-010 The write pointer SHALL be held as a NUM_REGS-bit one-hot ring, encoded to the 4-bit write_reg.
REQ-011 The one-hot ring SHALL rotate by one position per accepted beat, and wrap from NUM_REGS-1 to 0.
REQ-012 The one-hot ring SHALL hold its position when no beat is accepted.
REQ-013 write_count SHALL increment by 1 per accepted beat.
REQ-014 When the beat that makes write_count reach NUM_REGS is accepted:
- the FSM SHALL enter FULL on that same edge;
- frame_full SHALL be 1 from the next cycle;
- write_en for that last word SHALL be asserted in the same cycle that frame_full first reads 1.
REQ-015 In FULL, the block SHALL accept no beats and SHALL hold the write pointer.
REQ-016 In FULL, a read_done=1 at a rising edge SHALL cause all of the following on that edge:
- the FSM returns to FILL;
- frame_full is cleared;
- write_count is cleared to 0;
- the pointer is reloaded to INIT_WRITE_REG.
REQ-017 read_done received while in FILL SHALL be ignored and SHALL have no effect on any state.
REQ-018 in_valid received while in FULL SHALL be ignored. Upstream holds the word; no data SHALL be lost or duplicated.
REQ-019 The number of write_en pulses per frame SHALL be exactly NUM_REGS.
REQ-020 Within a frame, write_reg SHALL visit every address INIT_WRITE_REG..NUM_REGS-1, then 0..INIT_WRITE_REG-1, each exactly once.
REQ-021 write_reg SHALL never exceed NUM_REGS-1.
REQ-022 The pointer SHALL always be one-hot. If an illegal ring value is detected, the ring SHALL reload to INIT_WRITE_REG at the next edge.

Reset
REQ-023 While rst_n=0 at a rising edge, the block SHALL set:
- state=FILL
- pointer=one-hot(INIT_WRITE_REG)
- write_reg=INIT_WRITE_REG
- write_en=0
- write_data=0
- write_count=0
- frame_full=0
REQ-024 in_ready SHALL be 0 in every cycle where rst_n=0. It SHALL be 1 in the first cycle after rst_n rises.
REQ-025 A reset during a partial frame or during FULL SHALL discard the frame: no write_en after reset until a new beat is accepted.

Verification
REQ-026 The bench SHALL cover these directed scenarios, one per line (stimulus -> required response):
- Defaults, continuous in_valid=1, data 0x10..0x1E -> 15 write_en pulses; write_reg 0,1,..,14; write_data 0x10..0x1E; frame_full=1 with the last write; in_ready=0 afterwards.
- INIT_WRITE_REG=12, 15 beats -> write_reg 12,13,14,0,1,..,11; frame_full after the 15th beat.
- FULL with in_valid=1 held for 5 cycles, then read_done pulse -> no write_en during FULL; next edge in_ready=1, write_count=0; the next beat writes to INIT_WRITE_REG.
- read_done pulsed while in FILL with write_count=6 -> ignored; write_count stays 6; frame completes after 9 more beats.
- in_valid toggling 1,0,1,0 -> write_en only one cycle after each accepted beat; the pointer holds during gaps.
- rst_n=0 for 1 cycle after 7 beats -> all outputs at reset values; the next frame starts at INIT_WRITE_REG with write_count 0.
